// File: rtl/mul32_seq_pkg.sv
// mul32_seq_pkg: shared state encoding and sizing constants for the sequential multiplier.
package mul32_seq_pkg;
    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mul32_seq_add.sv
// Add: 32-bit carry-lookahead adder built from 4-bit groups; carry-out is dropped.
module Add
    import mul32_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);
    logic [DATA_W-1:0]   g;
    logic [DATA_W-1:0]   p;
    logic [DATA_W-1:0]   c;
    logic [DATA_W/4-1:0] gc;
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gc = '0;
        for (int k = 0; k < DATA_W / 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 1; j < 4; j++)
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            // group carry skips the intra-group chain using group generate/propagate
            if (k < DATA_W / 4 - 1)
                gc[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                        | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k +: 4]) & gc[k]);
        end
        sum = p ^ c;
    end
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: shift-and-add unsigned multiplier, fixed 32 iterations, low 32 bits of a*b.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, add_sum;
    logic [4:0]       cnt_q, cnt_d;

    Add u_add (.a(acc_q), .b(mcand_q), .sum(add_sum));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (state_q == ST_IDLE && in_valid) begin
            state_d  = ST_BUSY;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (state_q == ST_BUSY) begin
            acc_d    = mplier_q[0] ? add_sum : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            state_d  = (cnt_q == 5'(MUL_ITERS - 1)) ? ST_DONE : ST_BUSY;
        end else if (state_q == ST_DONE && out_ready) begin
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign busy      = state_q == ST_BUSY;
    assign out_valid = state_q == ST_DONE;
    assign result    = acc_q;
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: directed table, hand-written corner sequences and random ops against a product model.
module tb_mul32_seq;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [31:0] a = '0, b = '0, result;
    int          pass = 0, tot = 0;

    always #5 clk = ~clk;

    mul32_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        prod = {32'b0, x} * {32'b0, y};
        return prod[31:0];
    endfunction

    // lat counts rising edges after the accept edge until out_valid is first seen
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int stall,
                          output logic [31:0] r, output int lat, output int bcnt,
                          output logic stable, output logic idle_after);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        out_ready = 1'b0;
        in_valid = 1'b1; a = x; b = y;
        @(negedge clk);
        lat = 0; bcnt = 0; stable = 1'b1;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            if (in_ready) stable = 1'b0;
            in_valid = 1'($urandom); a = $urandom; b = $urandom; out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        r = result;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            if (!out_valid || result !== r) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        idle_after = in_ready && !out_valid && !busy;
        out_ready = 1'b0;
    endtask

    vec_t        vt[9];
    logic [31:0] r, pa[3], pb[3], pe[3];
    int          lat, bcnt, k, idx, cyc, last, bad, errs, n;
    logic        stable, idle_after, seen;

    initial begin
        vt[0] = '{32'd3, 32'd5, 32'd15, 0};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2};
        vt[2] = '{32'h00010000, 32'h00010000, 32'h00000000, 0};
        vt[3] = '{32'd7, 32'd6, 32'd42, 10};
        vt[4] = '{32'h0, 32'h89ABCDEF, 32'h0, 1};
        vt[5] = '{32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 0};
        vt[6] = '{32'h80000000, 32'h2, 32'h0, 3};
        vt[7] = '{32'h12345678, 32'h10, 32'h23456780, 0};
        vt[8] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);

        // accept on the very first edge after reset release
        rst_n = 1'b1; in_valid = 1'b1; a = 32'd11; b = 32'd3;
        @(negedge clk);
        chk("first_accept_busy", busy, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("first_accept_lat", n, 32);
        chk("first_accept_result", result, 33);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].a, vt[i].b, vt[i].stall, r, lat, bcnt, stable, idle_after);
            chk($sformatf("vec%0d_result", i), r, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 32);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32);
            chk($sformatf("vec%0d_stable", i), stable, 1);
            chk($sformatf("vec%0d_idle_after", i), idle_after, 1);
        end

        // reset in the middle of BUSY discards the operation
        @(negedge clk);
        in_valid = 1'b1; a = 32'h1234; b = 32'h10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("mid_rst_no_output", seen, 0);
        run_op(32'd2, 32'd9, 0, r, lat, bcnt, stable, idle_after);
        chk("after_rst_result", r, 18);
        chk("after_rst_latency", lat, 32);

        // back-to-back with in_valid held high
        pa = '{32'h0, 32'hDEADBEEF, 32'h80000000};
        pb = '{32'h89ABCDEF, 32'h1, 32'h2};
        pe = '{32'h0, 32'hDEADBEEF, 32'h0};
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        k = 0; idx = 0; cyc = 0; last = 0; bad = 0;
        while (k < 3 && cyc < 300) begin
            if (out_valid) begin
                chk($sformatf("b2b%0d_result", k), result, pe[k]);
                if (k > 0) chk($sformatf("b2b%0d_interval", k), cyc - last, 34);
                last = cyc;
                k++;
            end
            if (in_ready == (busy || out_valid)) bad++;
            if (in_ready) begin
                a = idx < 3 ? pa[idx] : 32'h0;
                b = idx < 3 ? pb[idx] : 32'h0;
                idx++;
            end else begin
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_count", k, 3);
        chk("b2b_in_ready_bad", bad, 0);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        out_ready = 1'b0;

        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 7 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(x, y, $urandom_range(0, 3), r, lat, bcnt, stable, idle_after);
            chk($sformatf("rand%0d_result", i), r, ref_mul(x, y));
            if (lat != 32 || bcnt != 32 || !stable || !idle_after) errs++;
        end
        chk("rand_timing_errors", errs, 0);

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
